// File: rtl/cursor_pkg.sv
// Shared constants for the cursor overlay: bitmap size, controller bit map,
// cursor colours, vsync detector states and the recentre helper.
package cursor_pkg;

  localparam int unsigned CURSOR_SIZE = 16;

  localparam logic [2:0] BTN_A      = 3'd7;
  localparam logic [2:0] BTN_B      = 3'd6;
  localparam logic [2:0] BTN_SELECT = 3'd5;
  localparam logic [2:0] BTN_START  = 3'd4;
  localparam logic [2:0] BTN_UP     = 3'd3;
  localparam logic [2:0] BTN_DOWN   = 3'd2;
  localparam logic [2:0] BTN_LEFT   = 3'd1;
  localparam logic [2:0] BTN_RIGHT  = 3'd0;

  localparam logic [23:0] COLOR_WHITE = 24'hFF_FF_FF;
  localparam logic [23:0] COLOR_GREEN = 24'h00_FF_00;

  typedef enum logic [1:0] {
    VS_WARM0,
    VS_WARM1,
    VS_WARM2,
    VS_RUN
  } vs_state_e;

  function automatic logic [9:0] center_pos(input int unsigned extent);
    return 10'((extent - CURSOR_SIZE) / 2);
  endfunction

endpackage

// File: rtl/mod_cursor_rom.sv
// 16x16 crosshair bitmap: border rows/cols plus the two centre rows/cols.
module mod_cursor_rom (
  input  logic [3:0] i_row,
  input  logic [3:0] i_col,
  output logic       o_bit
);

  localparam logic [15:0] BITMAP [16] = '{
    16'hFFFF, 16'h8181, 16'h8181, 16'h8181,
    16'h8181, 16'h8181, 16'h8181, 16'hFFFF,
    16'hFFFF, 16'h8181, 16'h8181, 16'h8181,
    16'h8181, 16'h8181, 16'h8181, 16'hFFFF
  };

  logic [15:0] w_row_bits;

  assign w_row_bits = BITMAP[i_row];
  assign o_bit      = w_row_bits[i_col];

endmodule

// File: rtl/mod_cursor_overlay.sv
// Cursor overlay: synchronizes controller buttons, moves a 16x16 crosshair once
// per frame on the vsync falling edge, and composites it over the RGB stream.
module mod_cursor_overlay
  import cursor_pkg::*;
#(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned FAST_STEP   = 4,
  parameter int unsigned HOLD_FRAMES = 16
) (
  input  logic       in_pix_clk,
  input  logic       in_reset_n,
  input  logic [9:0] in_pix_x,
  input  logic [9:0] in_pix_y,
  input  logic       in_vsync,
  input  logic [7:0] in_buttons,
  input  logic [7:0] in_pixel_r,
  input  logic [7:0] in_pixel_g,
  input  logic [7:0] in_pixel_b,
  output logic [7:0] out_pixel_r,
  output logic [7:0] out_pixel_g,
  output logic [7:0] out_pixel_b,
  output logic [9:0] out_cursor_x,
  output logic [9:0] out_cursor_y
);

  localparam logic signed [10:0] X_MAX    = 11'(SCREEN_W - CURSOR_SIZE);
  localparam logic signed [10:0] Y_MAX    = 11'(SCREEN_H - CURSOR_SIZE);
  localparam logic [9:0]         X_HOME   = center_pos(SCREEN_W);
  localparam logic [9:0]         Y_HOME   = center_pos(SCREEN_H);
  localparam logic signed [10:0] FAST     = 11'(FAST_STEP);
  localparam logic [7:0]         HOLD_THR = 8'(HOLD_FRAMES);

  logic [7:0] r_btn_meta;
  logic [7:0] r_btn_sync;
  logic       r_vs_meta;
  logic       r_vs_sync;
  logic       r_vs_prev;
  vs_state_e  r_vs_state;
  vs_state_e  w_vs_state_nxt;
  logic       w_tick;

  logic [9:0] r_cx;
  logic [9:0] r_cy;
  logic [7:0] r_hold;
  logic       r_green;
  logic       r_visible;
  logic       r_a_prev;
  logic       r_sel_prev;

  logic [9:0] w_cx_nxt;
  logic [9:0] w_cy_nxt;
  logic [7:0] w_hold_nxt;
  logic       w_green_nxt;
  logic       w_visible_nxt;
  logic       w_a_prev_nxt;
  logic       w_sel_prev_nxt;

  logic w_btn_a, w_btn_sel, w_btn_start, w_btn_up, w_btn_down, w_btn_left, w_btn_right;
  logic w_any_dir;
  logic w_unused_btn_b;

  logic signed [10:0] w_step;
  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic signed [10:0] w_nx;
  logic signed [10:0] w_ny;
  logic [9:0]         w_cx_clamped;
  logic [9:0]         w_cy_clamped;

  logic [9:0]  w_rel_x;
  logic [9:0]  w_rel_y;
  logic        w_in_box;
  logic        w_rom_bit;
  logic        w_hit;
  logic [23:0] w_color;
  logic [23:0] r_pix;

  // Synchronizers; the vsync chain idles high so reset looks like "not in sync".
  always_ff @(posedge in_pix_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_btn_meta <= '0;
      r_btn_sync <= '0;
      r_vs_meta  <= 1'b1;
      r_vs_sync  <= 1'b1;
      r_vs_prev  <= 1'b1;
      r_vs_state <= VS_WARM0;
    end else begin
      r_btn_meta <= in_buttons;
      r_btn_sync <= r_btn_meta;
      r_vs_meta  <= in_vsync;
      r_vs_sync  <= r_vs_meta;
      r_vs_prev  <= r_vs_sync;
      r_vs_state <= w_vs_state_nxt;
    end
  end

  // Edges are only trusted once prev/sync both hold post-reset samples, so a
  // vsync already low at reset release does not produce a tick.
  always_comb begin
    w_vs_state_nxt = r_vs_state;
    w_tick         = 1'b0;
    case (r_vs_state)
      VS_WARM0: w_vs_state_nxt = VS_WARM1;
      VS_WARM1: w_vs_state_nxt = VS_WARM2;
      VS_WARM2: w_vs_state_nxt = VS_RUN;
      VS_RUN:   w_tick         = r_vs_prev & ~r_vs_sync;
      default:  w_vs_state_nxt = VS_WARM0;
    endcase
  end

  assign w_btn_a        = r_btn_sync[BTN_A];
  assign w_btn_sel      = r_btn_sync[BTN_SELECT];
  assign w_btn_start    = r_btn_sync[BTN_START];
  assign w_btn_up       = r_btn_sync[BTN_UP];
  assign w_btn_down     = r_btn_sync[BTN_DOWN];
  assign w_btn_left     = r_btn_sync[BTN_LEFT];
  assign w_btn_right    = r_btn_sync[BTN_RIGHT];
  assign w_unused_btn_b = r_btn_sync[BTN_B];
  assign w_any_dir      = w_btn_up | w_btn_down | w_btn_left | w_btn_right;

  always_comb begin
    w_step = (r_hold >= HOLD_THR) ? FAST : 11'sd1;
    w_dx   = '0;
    w_dy   = '0;
    if (w_btn_left && !w_btn_right) w_dx = -w_step;
    else if (w_btn_right && !w_btn_left) w_dx = w_step;
    if (w_btn_up && !w_btn_down) w_dy = -w_step;
    else if (w_btn_down && !w_btn_up) w_dy = w_step;

    w_nx = $signed({1'b0, r_cx}) + w_dx;
    w_ny = $signed({1'b0, r_cy}) + w_dy;

    if (w_nx < 0)          w_cx_clamped = '0;
    else if (w_nx > X_MAX) w_cx_clamped = X_MAX[9:0];
    else                   w_cx_clamped = w_nx[9:0];

    if (w_ny < 0)          w_cy_clamped = '0;
    else if (w_ny > Y_MAX) w_cy_clamped = Y_MAX[9:0];
    else                   w_cy_clamped = w_ny[9:0];
  end

  always_comb begin
    w_cx_nxt       = r_cx;
    w_cy_nxt       = r_cy;
    w_hold_nxt     = r_hold;
    w_green_nxt    = r_green;
    w_visible_nxt  = r_visible;
    w_a_prev_nxt   = r_a_prev;
    w_sel_prev_nxt = r_sel_prev;
    if (w_tick) begin
      if (w_btn_start) begin
        w_cx_nxt   = X_HOME;
        w_cy_nxt   = Y_HOME;
        w_hold_nxt = '0;
      end else begin
        w_cx_nxt = w_cx_clamped;
        w_cy_nxt = w_cy_clamped;
        if (!w_any_dir)           w_hold_nxt = '0;
        else if (r_hold != 8'hFF) w_hold_nxt = r_hold + 8'd1;
      end
      if (w_btn_a && !r_a_prev)     w_green_nxt   = ~r_green;
      if (w_btn_sel && !r_sel_prev) w_visible_nxt = ~r_visible;
      w_a_prev_nxt   = w_btn_a;
      w_sel_prev_nxt = w_btn_sel;
    end
  end

  always_ff @(posedge in_pix_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_cx       <= X_HOME;
      r_cy       <= Y_HOME;
      r_hold     <= '0;
      r_green    <= 1'b0;
      r_visible  <= 1'b1;
      r_a_prev   <= 1'b0;
      r_sel_prev <= 1'b0;
    end else begin
      r_cx       <= w_cx_nxt;
      r_cy       <= w_cy_nxt;
      r_hold     <= w_hold_nxt;
      r_green    <= w_green_nxt;
      r_visible  <= w_visible_nxt;
      r_a_prev   <= w_a_prev_nxt;
      r_sel_prev <= w_sel_prev_nxt;
    end
  end

  // Unsigned wrap makes pixels left of/above the cursor land far outside [0,15].
  assign w_rel_x  = in_pix_x - r_cx;
  assign w_rel_y  = in_pix_y - r_cy;
  assign w_in_box = (w_rel_x[9:4] == '0) && (w_rel_y[9:4] == '0);

  mod_cursor_rom u_rom (
    .i_row (w_rel_y[3:0]),
    .i_col (w_rel_x[3:0]),
    .o_bit (w_rom_bit)
  );

  assign w_color = r_green ? COLOR_GREEN : COLOR_WHITE;
  assign w_hit   = r_visible & w_in_box & w_rom_bit;

  always_ff @(posedge in_pix_clk or negedge in_reset_n) begin
    if (!in_reset_n) r_pix <= '0;
    else             r_pix <= w_hit ? w_color : {in_pixel_r, in_pixel_g, in_pixel_b};
  end

  assign out_pixel_r  = r_pix[23:16];
  assign out_pixel_g  = r_pix[15:8];
  assign out_pixel_b  = r_pix[7:0];
  assign out_cursor_x = r_cx;
  assign out_cursor_y = r_cy;

endmodule
